// File: rtl/mul_controller_if.sv
// Bus bundle between the multiply controller, its requester and the shared ALU.
// Handshake: the requester raises start with operands valid; the controller
// accepts it only while idle (capturing the operands on that edge), signals
// busy while iterating, then pulses done for one cycle when product is valid.
// product then holds until the next accepted start.
interface mul_controller_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_p;
  logic [WIDTH-1:0]   alu_mul;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_cout;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  // Requester plus ALU side: drives request/operands and ALU results.
  modport master (
    output start, multiplicand, multiplier, alu_r, alu_cout,
    input  alu_op, alu_p, alu_mul, busy, done, product
  );

  // Controller side.
  modport slave (
    input  start, multiplicand, multiplier, alu_r, alu_cout,
    output alu_op, alu_p, alu_mul, busy, done, product
  );
endinterface

// File: rtl/mul_controller.sv
// Shift-and-add unsigned multiplier controller. The addition itself is done
// by an external shared ALU; this block sequences WIDTH add/shift steps over
// a {hi,lo} product register, with lo initially holding the multiplier.
module mul_controller #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_controller_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    count_q, count_d;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update: capture in IDLE, add/shift in CALC.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hi_d    = '0;
          lo_d    = bus.multiplier;
          mcand_d = bus.multiplicand;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // The carry-out becomes the new top bit; the bit shifted out of lo
        // has already been consumed as this step's add decision.
        if (lo_q[0]) begin
          {hi_d, lo_d} = {bus.alu_cout, bus.alu_r, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
        if (count_q == LAST) begin
          // Hold the counter on the final step so it never wraps mid-op.
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and registers.
  always_comb begin
    bus.alu_op  = (state_q == CALC) ? OP_ADD : OP_NOP;
    bus.alu_p   = hi_q;
    bus.alu_mul = mcand_q;
    bus.busy    = (state_q == CALC);
    bus.done    = (state_q == DONE);
    bus.product = {hi_q, lo_q};
    dbg_state_o = state_q;
  end

endmodule
